// File: rtl/axi_mem_responder_if.sv
// AXI4 subset bus between a master and axi_mem_responder.
// Carries the five channels (AW, W, B, AR, R). Only the signals the responder
// needs are present: IDs, addresses, burst length, data/strobe and handshakes.
//   slave  modport : the memory side (drives ready on AW/W/AR, valid on B/R)
//   master modport : the requesting side
interface axi_mem_responder_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_responder.sv
// Single-beat AXI memory responder backed by 2**DEPTH_LOG2 32-bit words.
// One transaction is in flight at a time; writes win over reads when both
// address channels are valid in the same idle cycle. Only single-beat
// (len==0), in-range accesses touch the memory; anything else is answered
// with SLVERR (and zero data for reads).
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset (memory contents are kept)
//   s_axi   : AXI slave bus (axi_mem_responder_if.slave)
module axi_mem_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axi_mem_responder_if.slave   s_axi
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                state_q, state_d;
    logic                  idle_q, idle_d;     // doubles as awready; 0 in/just after reset
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [3:0]            bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [3:0]            rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_ok_q, rd_ok_d;
    logic [3:0]            aw_id_q, aw_id_d;
    logic [DEPTH_LOG2-1:0] aw_idx_q, aw_idx_d;
    logic                  aw_ok_q, aw_ok_d;   // address in range and single beat

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_word_q;

    logic                  aw_hs, ar_hs, w_hs;
    logic                  wr_ok;
    logic                  aw_in_range, ar_in_range;
    logic [DEPTH_LOG2-1:0] ar_idx;
    logic                  unused_addr_lsbs;

    // Byte offset bits play no part in word addressing.
    assign unused_addr_lsbs = &{1'b0, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign aw_hs = s_axi.awvalid & idle_q;
    assign ar_hs = s_axi.arvalid & idle_q & ~s_axi.awvalid;
    assign w_hs  = s_axi.wvalid & wready_q;

    assign aw_in_range = (s_axi.awaddr[31:DEPTH_LOG2+2] == '0);
    assign ar_in_range = (s_axi.araddr[31:DEPTH_LOG2+2] == '0);
    assign ar_idx      = s_axi.araddr[DEPTH_LOG2+1:2];
    // wlast is only known at the data beat, so legality is finished here.
    assign wr_ok       = aw_ok_q & s_axi.wlast;

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        wready_d = wready_q;
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rd_ok_d  = rd_ok_q;
        aw_id_d  = aw_id_q;
        aw_idx_d = aw_idx_q;
        aw_ok_d  = aw_ok_q;

        case (state_q)
            IDLE: begin
                // Also raises the ready flag on the first cycle out of reset.
                idle_d = 1'b1;
                if (aw_hs) begin
                    state_d  = WR_DATA;
                    idle_d   = 1'b0;
                    wready_d = 1'b1;
                    aw_id_d  = s_axi.awid;
                    aw_idx_d = s_axi.awaddr[DEPTH_LOG2+1:2];
                    aw_ok_d  = aw_in_range & (s_axi.awlen == 8'd0);
                end else if (ar_hs) begin
                    state_d  = RD_DATA;
                    idle_d   = 1'b0;
                    rvalid_d = 1'b1;
                    rid_d    = s_axi.arid;
                    rd_ok_d  = ar_in_range & (s_axi.arlen == 8'd0);
                    rresp_d  = (ar_in_range && s_axi.arlen == 8'd0) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    state_d  = WR_RESP;
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    bid_d    = aw_id_q;
                    bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            WR_RESP: begin
                if (s_axi.bready) begin
                    state_d  = IDLE;
                    idle_d   = 1'b1;
                    bvalid_d = 1'b0;
                    bid_d    = '0;
                    bresp_d  = '0;
                end
            end
            RD_DATA: begin
                if (s_axi.rready) begin
                    state_d  = IDLE;
                    idle_d   = 1'b1;
                    rvalid_d = 1'b0;
                    rid_d    = '0;
                    rresp_d  = '0;
                    rd_ok_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                idle_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idle_q   <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rresp_q  <= '0;
            rd_ok_q  <= 1'b0;
            aw_id_q  <= '0;
            aw_idx_q <= '0;
            aw_ok_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            wready_q <= wready_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            rd_ok_q  <= rd_ok_d;
            aw_id_q  <= aw_id_d;
            aw_idx_q <= aw_idx_d;
            aw_ok_q  <= aw_ok_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    // Handshakes are impossible during reset since both readies are held low.
    always_ff @(posedge clk) begin
        if (w_hs && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (s_axi.wstrb[i]) mem[aw_idx_q][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
        if (ar_hs) rd_word_q <= mem[ar_idx];
    end

    assign s_axi.awready = idle_q;
    assign s_axi.arready = idle_q & ~s_axi.awvalid;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rvalid_q;
    // Illegal reads return zero; rd_ok_q is also low through reset.
    assign s_axi.rdata   = rd_ok_q ? rd_word_q : 32'd0;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus tasks push expected B/R
// responses computed from a word-array model; a monitor pops and compares
// whenever the DUT completes a B or R handshake.
module tb_axi_mem_responder;
    logic clk;
    logic reset_n;
    axi_mem_responder_if s_axi();

    axi_mem_responder #(.DEPTH_LOG2(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_axi   (s_axi)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] mdl [1024];
    int          n_cmp;
    int          n_bad;
    bit          mon_ar_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [49:0] outs();
        return {s_axi.awready, s_axi.arready, s_axi.wready, s_axi.bvalid, s_axi.bid,
                s_axi.bresp, s_axi.rvalid, s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0: return s_axi.awready;
            1: return s_axi.arready;
            2: return s_axi.wready;
            3: return s_axi.bvalid;
            4: return s_axi.rvalid;
            default: return 1'b0;
        endcase
    endfunction

    // Returns at the negedge where the selected signal is seen high.
    task automatic wait_sig(input int sel, input string name, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (sig(sel) === 1'b1) break;
            cyc++;
            if (cyc > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout_%s: not seen in 50 cycles, required high", name);
                break;
            end
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] len, input bit last,
                             input int bdly, input bit hold_chk, input bit ar_chk);
        bit legal;
        int c;
        logic [1:0] er;
        legal = (addr[31:12] == 20'd0) && (len == 8'd0) && last;
        er = legal ? 2'b00 : 2'b10;
        if (legal)
            for (int i = 0; i < 4; i++)
                if (strb[i]) mdl[addr[11:2]][8*i +: 8] = data[8*i +: 8];
        exp_b.push_back('{id: id, resp: er});
        s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awvalid = 1'b1;
        if (ar_chk) begin
            @(negedge clk);
            check("ar_blocked_by_aw", s_axi.arready, 0);
            check("aw_accept_first", s_axi.awready, 1);
        end else begin
            wait_sig(0, "awready", c);
        end
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;
        s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = last; s_axi.wvalid = 1'b1;
        wait_sig(2, "wready", c);
        @(posedge clk); #1;
        s_axi.wvalid = 1'b0;
        wait_sig(3, "bvalid", c);
        for (int k = 0; k < bdly; k++) begin
            if (hold_chk) begin
                check("b_hold_valid", s_axi.bvalid, 1);
                check("b_hold_id", s_axi.bid, id);
                check("b_hold_resp", s_axi.bresp, er);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_axi.bready = 1'b1;
        @(posedge clk); #1;
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int rdly, input bit hold_chk, input bit first_chk);
        bit legal;
        int c;
        r_exp_t e;
        legal = (addr[31:12] == 20'd0) && (len == 8'd0);
        e.id = id;
        e.data = legal ? mdl[addr[11:2]] : 32'd0;
        e.resp = legal ? 2'b00 : 2'b10;
        exp_r.push_back(e);
        s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len; s_axi.arvalid = 1'b1;
        wait_sig(1, "arready", c);
        if (first_chk) check("ar_first_idle_cycle", c, 0);
        @(posedge clk); #1;
        s_axi.arvalid = 1'b0;
        wait_sig(4, "rvalid", c);
        for (int k = 0; k < rdly; k++) begin
            if (hold_chk) begin
                check("r_hold_valid", s_axi.rvalid, 1);
                check("r_hold_id", s_axi.rid, e.id);
                check("r_hold_data", s_axi.rdata, e.data);
                check("r_hold_resp", s_axi.rresp, e.resp);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_axi.rready = 1'b1;
        @(posedge clk); #1;
        s_axi.rready = 1'b0;
    endtask

    // Monitor: compares every completed B/R handshake with the queued expectation.
    initial begin
        mon_ar_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                mon_ar_seen = 1'b0;
                continue;
            end
            if (mon_ar_seen) check("r_latency_1cycle", s_axi.rvalid, 1);
            mon_ar_seen = s_axi.arvalid && s_axi.arready;
            if (s_axi.bvalid && s_axi.bready) begin
                if (exp_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected: got bid %0h, expected no response", s_axi.bid);
                end else begin
                    b_exp_t e;
                    e = exp_b.pop_front();
                    check("bid", s_axi.bid, e.id);
                    check("bresp", s_axi.bresp, e.resp);
                end
            end
            if (s_axi.rvalid && s_axi.rready) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_unexpected: got rid %0h, expected no response", s_axi.rid);
                end else begin
                    r_exp_t e;
                    e = exp_r.pop_front();
                    check("rid", s_axi.rid, e.id);
                    check("rdata", s_axi.rdata, e.data);
                    check("rresp", s_axi.rresp, e.resp);
                    check("rlast", s_axi.rlast, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [7:0]  len;
        bit          last;
        int          c;

        reset_n = 1'b0;
        s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        for (int i = 0; i < 1024; i++) mdl[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs_zero", outs(), 0);
        s_axi.awvalid = 1'b1;
        s_axi.arvalid = 1'b1;
        @(negedge clk);
        check("reset_ready_low", {s_axi.awready, s_axi.arready}, 0);
        s_axi.awvalid = 1'b0;
        s_axi.arvalid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Seed the 16 words used by random traffic so every read is defined.
        for (int i = 0; i < 16; i++)
            axi_write(4'($urandom), 32'(i * 4), $urandom, 4'hF, 8'd0, 1'b1, 0, 0, 0);

        // Basic write/read at 0x10, then partial strobe merge.
        axi_write(4'd1, 32'h10, 32'hDEADBEEF, 4'hF, 8'd0, 1'b1, 0, 0, 0);
        axi_read(4'd2, 32'h10, 8'd0, 0, 0, 0);
        axi_write(4'd3, 32'h10, 32'h11223344, 4'b0101, 8'd0, 1'b1, 0, 0, 0);
        axi_read(4'd4, 32'h13, 8'd0, 0, 0, 0);

        // Illegal accesses: out of range and multi-beat.
        axi_write(4'd5, 32'h1000, 32'hCAFEF00D, 4'hF, 8'd0, 1'b1, 0, 0, 0);
        axi_read(4'd6, 32'h1000, 8'd0, 0, 0, 0);
        axi_write(4'd7, 32'h10, 32'h55555555, 4'hF, 8'd1, 1'b1, 0, 0, 0);
        axi_read(4'd8, 32'h10, 8'd0, 0, 0, 0);
        axi_read(4'd9, 32'h0, 8'd0, 0, 0, 0);
        axi_read(4'd10, 32'h10, 8'd3, 0, 0, 0);

        // Simultaneous AW/AR: write first, read taken in the first idle cycle.
        s_axi.arid = 4'hC; s_axi.araddr = 32'h20; s_axi.arlen = 8'd0; s_axi.arvalid = 1'b1;
        axi_write(4'hB, 32'h20, 32'hA5A5_0F0F, 4'hF, 8'd0, 1'b1, 0, 0, 1);
        axi_read(4'hC, 32'h20, 8'd0, 0, 0, 1);

        // Back-pressure: responses held 5 cycles.
        axi_write(4'hD, 32'h24, 32'h0BAD_CAFE, 4'hF, 8'd0, 1'b1, 5, 1, 0);
        axi_read(4'hE, 32'h24, 8'd0, 5, 1, 0);
        axi_read(4'hF, 32'h2000, 8'd0, 5, 1, 0);

        // Reset while in WR_DATA before any data beat: no response, no write.
        s_axi.awid = 4'h6; s_axi.awaddr = 32'h28; s_axi.awlen = 8'd0; s_axi.awvalid = 1'b1;
        wait_sig(0, "awready", c);
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;
        s_axi.wdata = 32'hFFFF_FFFF; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b1;
        @(negedge clk);
        check("wr_data_wready", s_axi.wready, 1);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs_zero", outs(), 0);
        repeat (2) @(negedge clk);
        check("midreset_held_zero", outs(), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        axi_read(4'h1, 32'h28, 8'd0, 0, 0, 0);

        // Randomized mix.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                addr = $urandom;
                if (addr[31:12] == 20'd0) addr[12] = 1'b1;
            end else begin
                addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end
            len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            last = (len == 8'd0) ? ($urandom_range(0, 9) != 0) : 1'($urandom);
            if ($urandom_range(0, 1) == 0)
                axi_write(4'($urandom), addr, $urandom, 4'($urandom), len, last,
                          $urandom_range(0, 3), 1, 0);
            else
                axi_read(4'($urandom), addr, len, $urandom_range(0, 3), 1, 0);
        end

        repeat (5) @(negedge clk);
        check("b_queue_drained", exp_b.size(), 0);
        check("r_queue_drained", exp_r.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words in the internal memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port s_axi_awid  input  4  write ID.
REQ-005 SHALL have port s_axi_awaddr  input  32  write byte address.
REQ-006 SHALL have port s_axi_awlen  input  8  write burst length minus 1.
REQ-007 SHALL have port s_axi_awvalid  input  1  write address valid.
REQ-008 SHALL have port s_axi_awready  output  1  write address accepted.
REQ-009 SHALL have port s_axi_wdata  input  32  write data.
REQ-010 SHALL have port s_axi_wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
REQ-011 SHALL have port s_axi_wlast  input  1  last write beat.
REQ-012 SHALL have port s_axi_wvalid  input  1  write data valid.
REQ-013 SHALL have port s_axi_wready  output  1  write data accepted.
REQ-014 SHALL have port s_axi_bid  output  4  response ID.
REQ-015 SHALL have port s_axi_bresp  output  2  write response, 00 OKAY or 10 SLVERR.
REQ-016 SHALL have port s_axi_bvalid  output  1  write response valid.
REQ-017 SHALL have port s_axi_bready  input  1  write response accepted.
REQ-018 SHALL have port s_axi_arid  input  4  read ID.
REQ-019 SHALL have port s_axi_araddr  input  32  read byte address.
REQ-020 SHALL have port s_axi_arlen  input  8  read burst length minus 1.
REQ-021 SHALL have port s_axi_arvalid  input  1  read address valid.
REQ-022 SHALL have port s_axi_arready  output  1  read address accepted.
REQ-023 SHALL have port s_axi_rid  output  4  read ID.
REQ-024 SHALL have port s_axi_rdata  output  32  read data.
REQ-025 SHALL have port s_axi_rresp  output  2  read response, 00 OKAY or 10 SLVERR.
REQ-026 SHALL have port s_axi_rlast  output  1  last read beat.
REQ-027 SHALL have port s_axi_rvalid  output  1  read data valid.
REQ-028 SHALL have port s_axi_rready  input  1  read data accepted.

Function
REQ-029 SHALL implement FSM states IDLE, WR_DATA, WR_RESP, RD_DATA and process one transaction at a time.
REQ-030 SHALL, in IDLE: awready=1; arready = !awvalid (write priority on simultaneous awvalid/arvalid); all other ready/valid outputs 0.
REQ-031 SHALL, on aw handshake: latch awid, awaddr, awlen; next state WR_DATA.
REQ-032 SHALL, in WR_DATA: wready=1; on w handshake, go to WR_RESP next cycle.
REQ-033 SHALL, on the w handshake, write the word at index awaddr[DEPTH_LOG2+1:2] under wstrb only if the write is legal, i.e. awaddr[31:DEPTH_LOG2+2]==0, awlen==0 and wlast==1.
REQ-034 SHALL ignore awaddr[1:0] and araddr[1:0].
REQ-035 SHALL, in WR_RESP: bvalid=1, bid=latched awid, bresp=00 if legal else 10; hold stable until bready; on handshake return to IDLE.
REQ-036 SHALL perform no memory write for an illegal write.
REQ-037 SHALL, on ar handshake: latch arid; perform a registered memory read; assert rvalid in the next cycle (state RD_DATA), i.e. 1-cycle latency.
REQ-038 SHALL, in RD_DATA: rid=latched arid, rlast=1, rresp=00 with memory data; if araddr is out of range or arlen!=0, rresp=10 and rdata=0.
REQ-039 SHALL hold rid/rdata/rresp stable until rready, then return to IDLE; IDLE SHALL be reachable within one cycle of a b or r handshake.
REQ-040 SHALL return data that reflects all completed writes when a read follows a write.
REQ-041 SHALL not depend on valid signals being deasserted between transactions; back-to-back requests SHALL be accepted in the first IDLE cycle.

Reset
REQ-042 SHALL, while reset_n=0, force state IDLE and drive all outputs to 0, including awready and arready.
REQ-043 SHALL not clear or initialise memory contents on reset.
REQ-044 SHALL, on reset mid-transaction, abandon the transaction with no response issued and no memory write unless its w handshake already occurred.

Verification
REQ-045 SHALL cover: write addr 0x10, data 0xDEADBEEF, wstrb 1111, id 1 -> bresp 00, bid 1; read 0x10 with id 2 -> rdata 0xDEADBEEF, rid 2, rlast 1, rvalid one cycle after ar handshake.
REQ-046 SHALL cover: write 0x10 with data 0x11223344, wstrb 0101 over 0xDEADBEEF -> subsequent read returns 0xDE22BE44.
REQ-047 SHALL cover: write to 0x1000 (DEPTH_LOG2=10), then read 0x1000 and awlen=1 write -> bresp 10, rresp 10, rdata 0, memory unchanged.
REQ-048 SHALL cover: awvalid and arvalid asserted in the same cycle -> arready=0, write completes first, read accepted in the first IDLE cycle after the b handshake.
REQ-049 SHALL cover: bready and rready held low for 5 cycles -> bvalid/rvalid and payload stable for all 5 cycles; reset_n pulsed low in WR_DATA -> all outputs 0 and no write performed.
